// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions: address-width helper and delay-line limits.
package dsp_pkg;

   // Largest delay-line depth the datapath is expected to instantiate.
   localparam int DELAY_LINE_MAX_DEPTH = 1024;

   // Delay-select / pointer width for a power-of-2 depth.
   function automatic int dl_aw(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/delay_line_ce_if.sv
// Sample/control bundle of the adjustable delay line.
// The master side drives ce/flush/d/a; the slave side returns y/vld/fill.
interface delay_line_ce_if
   import dsp_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 32,
   parameter int AW    = dl_aw(DEPTH)
);
   logic          ce;
   logic          flush;
   logic [W-1:0]  d;
   logic [AW-1:0] a;
   logic [W-1:0]  y;
   logic          vld;
   logic [AW:0]   fill;

   modport master (output ce, flush, d, a, input  y, vld, fill);
   modport slave  (input  ce, flush, d, a, output y, vld, fill);
endinterface

// File: rtl/dly_ram_sdp.sv
// Simple dual-port W x DEPTH RAM: synchronous write, asynchronous read.
// Kept separate so a block-RAM variant can be swapped in later.
module dly_ram_sdp #(
   parameter int W     = 8,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [W-1:0]  wd,
   input  logic [AW-1:0] ra,
   output logic [W-1:0]  rd
);
   logic [W-1:0] mem [DEPTH];

   // Write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   assign rd = mem[ra];
endmodule

// File: rtl/delay_line_ce.sv
// Adjustable-length word delay line built as a circular buffer.
// Output y is the sample pushed 'a' pushes before the current one, registered.
// Optional macro DELAY_LINE_ZERO_FILL_EN: behave as if the history were all
// zeros, so every push yields vld=1 and y=0 while the line is still priming.
module delay_line_ce
   import dsp_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 32,
   parameter int AW    = dl_aw(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   delay_line_ce_if.slave bus
);
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   logic [AW-1:0] wp;
   logic [AW:0]   fill;
   logic [AW:0]   fill_nxt;
   logic [AW-1:0] ra;
   logic [W-1:0]  rd;
   logic [W-1:0]  data_sel;
   logic [W-1:0]  y_q;
   logic          vld_q;
   logic          push;
   logic          primed;

   // A flush discards any simultaneous push.
   assign push     = bus.ce & ~bus.flush;
   assign fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
   // Pointer arithmetic wraps naturally because DEPTH is a power of 2.
   assign ra       = wp - bus.a;
   assign primed   = fill_nxt > {1'b0, bus.a};
   // a=0 would read the slot being written this cycle, so bypass the RAM.
   assign data_sel = (bus.a == '0) ? bus.d : rd;

   dly_ram_sdp #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk (clk),
      .we  (push),
      .wa  (wp),
      .wd  (bus.d),
      .ra  (ra),
      .rd  (rd)
   );

   // Pointer, fill tracker and registered output; y holds across flush and idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         fill  <= '0;
         vld_q <= 1'b0;
         y_q   <= '0;
      end else if (bus.flush) begin
         wp    <= '0;
         fill  <= '0;
         vld_q <= 1'b0;
      end else if (bus.ce) begin
         wp   <= wp + 1'b1;
         fill <= fill_nxt;
`ifdef DELAY_LINE_ZERO_FILL_EN
         vld_q <= 1'b1;
         y_q   <= primed ? data_sel : '0;
`else
         vld_q <= primed;
         y_q   <= data_sel;
`endif
      end else begin
         vld_q <= 1'b0;
      end
   end

   assign bus.y    = y_q;
   assign bus.vld  = vld_q;
   assign bus.fill = fill;
endmodule

// File: tb/tb_delay_line_ce.sv
// Directed self-checking bench for delay_line_ce (W=8, DEPTH=32).
module tb_delay_line_ce;
   import dsp_pkg::*;

   localparam int W     = 8;
   localparam int DEPTH = 32;
`ifdef DELAY_LINE_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   delay_line_ce_if #(.W(W), .DEPTH(DEPTH)) bus ();

   delay_line_ce #(.W(W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] v);
      bus.ce = 1'b1;
      bus.d  = v;
      step();
      bus.ce = 1'b0;
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (bus.y !== 8'h00) begin n_err++; $display("FAIL reset_y got %h want 00", bus.y); end
      n_cmp++; if (bus.vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", bus.vld); end
      n_cmp++; if (bus.fill !== 6'd0) begin n_err++; $display("FAIL reset_fill got %0d want 0", bus.fill); end
      #1 rst_n = 1'b1;
      step();
   endtask

   task automatic test_prime();
      logic [5:0] ef;
      logic       ev;
      logic [7:0] ey;
      bus.a = 5'd3;
      for (int i = 1; i <= 8; i++) begin
         push(8'(i));
         ef = 6'(i);
         ev = ZF ? 1'b1 : (i > 3);
         ey = (i > 3) ? 8'(i - 3) : 8'h00;
         n_cmp++; if (bus.fill !== ef) begin n_err++; $display("FAIL prime_fill[%0d] got %0d want %0d", i, bus.fill, ef); end
         n_cmp++; if (bus.vld !== ev) begin n_err++; $display("FAIL prime_vld[%0d] got %b want %b", i, bus.vld, ev); end
         if (ev) begin
            n_cmp++; if (bus.y !== ey) begin n_err++; $display("FAIL prime_y[%0d] got %h want %h", i, bus.y, ey); end
         end
      end
      step();
      n_cmp++; if (bus.vld !== 1'b0) begin n_err++; $display("FAIL idle_vld got %b want 0", bus.vld); end
      n_cmp++; if (bus.y !== 8'h05) begin n_err++; $display("FAIL idle_y got %h want 05", bus.y); end
      n_cmp++; if (bus.fill !== 6'd8) begin n_err++; $display("FAIL idle_fill got %0d want 8", bus.fill); end
   endtask

   task automatic test_bypass();
      bus.a = 5'd0;
      push(8'hA5);
      n_cmp++; if (bus.y !== 8'hA5) begin n_err++; $display("FAIL bypass_y got %h want a5", bus.y); end
      n_cmp++; if (bus.vld !== 1'b1) begin n_err++; $display("FAIL bypass_vld got %b want 1", bus.vld); end
      n_cmp++; if (bus.fill !== 6'd9) begin n_err++; $display("FAIL bypass_fill got %0d want 9", bus.fill); end
      for (int g = 0; g < 2; g++) begin
         step();
         n_cmp++; if (bus.y !== 8'hA5) begin n_err++; $display("FAIL gap_y[%0d] got %h want a5", g, bus.y); end
         n_cmp++; if (bus.vld !== 1'b0) begin n_err++; $display("FAIL gap_vld[%0d] got %b want 0", g, bus.vld); end
      end
      push(8'h5A);
      n_cmp++; if (bus.y !== 8'h5A) begin n_err++; $display("FAIL bypass2_y got %h want 5a", bus.y); end
      n_cmp++; if (bus.vld !== 1'b1) begin n_err++; $display("FAIL bypass2_vld got %b want 1", bus.vld); end
   endtask

   task automatic test_wrap();
      logic [5:0] ef;
      logic       ev;
      logic [7:0] ey;
      do_flush();
      n_cmp++; if (bus.fill !== 6'd0) begin n_err++; $display("FAIL flush_fill got %0d want 0", bus.fill); end
      n_cmp++; if (bus.vld !== 1'b0) begin n_err++; $display("FAIL flush_vld got %b want 0", bus.vld); end
      bus.a = 5'd31;
      for (int n = 0; n < 100; n++) begin
         push(8'(n));
         ef = (n + 1 > 32) ? 6'd32 : 6'(n + 1);
         ev = ZF ? 1'b1 : (n >= 31);
         ey = (n >= 31) ? 8'(n - 31) : 8'h00;
         n_cmp++; if (bus.fill !== ef) begin n_err++; $display("FAIL wrap_fill[%0d] got %0d want %0d", n, bus.fill, ef); end
         n_cmp++; if (bus.vld !== ev) begin n_err++; $display("FAIL wrap_vld[%0d] got %b want %b", n, bus.vld, ev); end
         if (ev) begin
            n_cmp++; if (bus.y !== ey) begin n_err++; $display("FAIL wrap_y[%0d] got %h want %h", n, bus.y, ey); end
         end
      end
   endtask

   task automatic test_delay_change();
      logic       ev;
      do_flush();
      bus.a = 5'd5;
      for (int k = 0; k < 20; k++) push(8'h40 + 8'(k));
      n_cmp++; if (bus.y !== 8'h4E) begin n_err++; $display("FAIL dchg_a5_y got %h want 4e", bus.y); end
      bus.a = 5'd10;
      push(8'h54);
      n_cmp++; if (bus.y !== 8'h4A) begin n_err++; $display("FAIL dchg_a10_y got %h want 4a", bus.y); end
      n_cmp++; if (bus.vld !== 1'b1) begin n_err++; $display("FAIL dchg_a10_vld got %b want 1", bus.vld); end
      do_flush();
      for (int k = 0; k <= 10; k++) begin
         push(8'h80 + 8'(k));
         ev = ZF ? 1'b1 : (k == 10);
         n_cmp++; if (bus.vld !== ev) begin n_err++; $display("FAIL refill_vld[%0d] got %b want %b", k, bus.vld, ev); end
         if (ev) begin
            n_cmp++; if (bus.y !== ((k == 10) ? 8'h80 : 8'h00)) begin n_err++; $display("FAIL refill_y[%0d] got %h", k, bus.y); end
         end
      end
   endtask

   task automatic test_flush_ce();
      bus.ce    = 1'b1;
      bus.flush = 1'b1;
      bus.d     = 8'h33;
      step();
      bus.ce    = 1'b0;
      bus.flush = 1'b0;
      n_cmp++; if (bus.fill !== 6'd0) begin n_err++; $display("FAIL fce_fill got %0d want 0", bus.fill); end
      n_cmp++; if (bus.vld !== 1'b0) begin n_err++; $display("FAIL fce_vld got %b want 0", bus.vld); end
      n_cmp++; if (bus.y !== 8'h80) begin n_err++; $display("FAIL fce_yhold got %h want 80", bus.y); end
      bus.a = 5'd1;
      push(8'h44);
      n_cmp++; if (bus.fill !== 6'd1) begin n_err++; $display("FAIL fce_fill1 got %0d want 1", bus.fill); end
      n_cmp++; if (bus.vld !== ZF) begin n_err++; $display("FAIL fce_vld1 got %b want %b", bus.vld, ZF); end
      push(8'h55);
      n_cmp++; if (bus.y !== 8'h44) begin n_err++; $display("FAIL fce_y2 got %h want 44", bus.y); end
      n_cmp++; if (bus.vld !== 1'b1) begin n_err++; $display("FAIL fce_vld2 got %b want 1", bus.vld); end
      n_cmp++; if (bus.fill !== 6'd2) begin n_err++; $display("FAIL fce_fill2 got %0d want 2", bus.fill); end
   endtask

   task automatic test_async_reset();
      bus.a = 5'd0;
      push(8'h77);
      n_cmp++; if (bus.y !== 8'h77) begin n_err++; $display("FAIL ar_pre_y got %h want 77", bus.y); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.y !== 8'h00) begin n_err++; $display("FAIL ar_y got %h want 00", bus.y); end
      n_cmp++; if (bus.vld !== 1'b0) begin n_err++; $display("FAIL ar_vld got %b want 0", bus.vld); end
      n_cmp++; if (bus.fill !== 6'd0) begin n_err++; $display("FAIL ar_fill got %0d want 0", bus.fill); end
      step();
      rst_n = 1'b1;
      bus.a = 5'd2;
      push(8'h01);
      n_cmp++; if (bus.vld !== ZF) begin n_err++; $display("FAIL ar_p1_vld got %b want %b", bus.vld, ZF); end
      push(8'h02);
      n_cmp++; if (bus.vld !== ZF) begin n_err++; $display("FAIL ar_p2_vld got %b want %b", bus.vld, ZF); end
      push(8'h03);
      n_cmp++; if (bus.y !== 8'h01) begin n_err++; $display("FAIL ar_p3_y got %h want 01", bus.y); end
      n_cmp++; if (bus.vld !== 1'b1) begin n_err++; $display("FAIL ar_p3_vld got %b want 1", bus.vld); end
      n_cmp++; if (bus.fill !== 6'd3) begin n_err++; $display("FAIL ar_p3_fill got %0d want 3", bus.fill); end
   endtask

`ifdef DELAY_LINE_ZERO_FILL_EN
   task automatic test_zero_fill();
      logic [7:0] ey [6];
      ey = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h12};
      do_flush();
      bus.a = 5'd4;
      for (int i = 0; i < 6; i++) begin
         push(8'h11 + 8'(i));
         n_cmp++; if (bus.y !== ey[i]) begin n_err++; $display("FAIL zf_y[%0d] got %h want %h", i, bus.y, ey[i]); end
         n_cmp++; if (bus.vld !== 1'b1) begin n_err++; $display("FAIL zf_vld[%0d] got %b want 1", i, bus.vld); end
      end
   endtask
`endif

   initial begin
      bus.ce    = 1'b0;
      bus.flush = 1'b0;
      bus.d     = '0;
      bus.a     = '0;
      test_reset();
      test_prime();
      test_bypass();
      test_wrap();
      test_delay_change();
      test_flush_ce();
      test_async_reset();
`ifdef DELAY_LINE_ZERO_FILL_EN
      test_zero_fill();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
